// File: rtl/mem_responder.sv
// Backing-memory responder for the direct-mapped cache.
// Serves one single-word read or write at a time over valid/ready request and
// response channels, and answers a fixed LATENCY cycles after acceptance.
module mem_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_BITS = 8,
    parameter int LATENCY    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic [ADDR_WIDTH-1:0] resp_addr
);

    localparam int         DEPTH    = 1 << DEPTH_BITS;
    localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [7:0]              cnt;
    logic                    lat_write;
    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic [DATA_WIDTH-1:0]   lat_wdata;
    logic                    accept;
    logic                    commit;
    logic                    release_resp;
    logic [DEPTH_BITS-1:0]   idx;

    // Storage array plus one "written since reset" bit per word.
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DEPTH-1:0]        written;

    // Upper address bits alias onto the same word.
    assign idx = lat_addr[DEPTH_BITS-1:0];

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state and handshake decode.
    always_comb begin
        // NOTE: every output gets a default first, so no path through the case infers a latch.
        state_next   = state;
        req_ready    = 1'b0;
        accept       = 1'b0;
        commit       = 1'b0;
        release_resp = 1'b0;
        case (state)
            IDLE: begin
                req_ready = rst_n;
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 8'd0) begin
                    commit     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    release_resp = 1'b1;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Latency counter and request capture at the accepting edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= 8'd0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (accept) begin
            cnt       <= CNT_LOAD;
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
        end else if (state == WAIT && cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
        end
    end

    // Storage data: written on the commit edge of a write.
    // NOTE: the array itself has no reset; clearing is done through the written[] bits so it can map to RAM.
    always_ff @(posedge clk) begin
        if (commit && lat_write) mem[idx] <= lat_wdata;
    end

    // Per-word written flags; reset makes every word read back as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  written      <= '0;
        else if (commit && lat_write) written[idx] <= 1'b1;
    end

    // Response registers: loaded at commit, held until the response handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_addr  <= '0;
        end else if (commit) begin
            resp_valid <= 1'b1;
            resp_addr  <= lat_addr;
            if (lat_write)        resp_rdata <= lat_wdata;
            else if (written[idx]) resp_rdata <= mem[idx];
            else                  resp_rdata <= '0;
        end else if (release_resp) begin
            resp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios followed by
// randomized transactions checked against a word-array reference model.
module tb_mem_responder;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [31:0] resp_addr;

    int passed = 0;
    int total  = 0;
    int accepted = 0;
    int valid_rises = 0;
    logic prev_valid = 1'b0;

    // Reference storage: 256 words, indexed by address modulo 256.
    logic [31:0] model [256];

    mem_responder #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .DEPTH_BITS(8),
        .LATENCY(LAT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_addr(resp_addr)
    );

    always #5 clk = ~clk;

    // Count response assertions independently of the stimulus flow.
    always @(negedge clk) begin
        if (resp_valid === 1'b1 && prev_valid !== 1'b1) valid_rises++;
        prev_valid = resp_valid;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) model[i] = 32'h0;
    endtask

    // One complete transaction: accept, fixed latency, optional backpressure, handshake.
    task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input int stall, input bit pulse);
        logic [31:0] exp_d;
        int waitc;
        waitc = 0;
        while (req_ready !== 1'b1 && waitc < 20) begin
            step();
            waitc++;
        end
        check("req_ready_idle", req_ready, 1);
        exp_d = wr ? wdata : model[addr % 256];
        if (wr) model[addr % 256] = wdata;
        req_valid  = 1'b1;
        req_write  = wr;
        req_addr   = addr;
        req_wdata  = wdata;
        resp_ready = $urandom_range(0, 1);
        step();
        accepted++;
        // Request inputs and resp_ready are don't-cares while the access is pending.
        for (int k = 0; k < LAT; k++) begin
            check("wait_valid_low", resp_valid, 0);
            check("wait_ready_low", req_ready, 0);
            req_valid  = $urandom_range(0, 1);
            req_write  = $urandom_range(0, 1);
            req_addr   = $urandom;
            req_wdata  = $urandom;
            resp_ready = (k == LAT - 1) ? (stall == 0) : $urandom_range(0, 1);
            step();
        end
        check("resp_valid", resp_valid, 1);
        check("resp_rdata", resp_rdata, exp_d);
        check("resp_addr", resp_addr, addr);
        for (int s = 0; s < stall; s++) begin
            req_valid = pulse && (s < 2);
            req_addr  = $urandom;
            step();
            check("stall_valid", resp_valid, 1);
            check("stall_rdata", resp_rdata, exp_d);
            check("stall_addr", resp_addr, addr);
            check("stall_req_ready", req_ready, 0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        step();
        check("release_valid", resp_valid, 0);
        check("release_req_ready", req_ready, 1);
    endtask

    initial begin
        logic        wr;
        logic [31:0] a;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;
        model_clear();

        // Reset then idle.
        #1;
        check("rst_req_ready", req_ready, 0);
        step();
        step();
        check("rst_req_ready_held", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_resp_addr", resp_addr, 0);
        rst_n = 1'b1;
        #1;
        check("post_rst_req_ready", req_ready, 1);
        step();

        // Write then read back.
        txn(1'b1, 32'h0000_0014, 32'hDEAD_BEEF, 0, 1'b0);
        txn(1'b0, 32'h0000_0014, 32'h0, 0, 1'b0);

        // Backpressure with a stray request pulse.
        txn(1'b0, 32'h0000_0014, 32'h0, 5, 1'b1);
        repeat (3) begin
            step();
            check("no_stray_accept", resp_valid, 0);
        end

        // Aliasing onto the same word.
        txn(1'b1, 32'h0000_0105, 32'h1111_1111, 0, 1'b0);
        txn(1'b0, 32'h0000_0005, 32'h0, 0, 1'b0);

        // Reset one cycle after accepting a write.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h0000_0020;
        req_wdata = 32'hAAAA_5555;
        step();
        req_valid = 1'b0;
        step();
        rst_n = 1'b0;
        model_clear();
        #1;
        check("midwait_rst_req_ready", req_ready, 0);
        check("midwait_rst_valid", resp_valid, 0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (LAT + 2) begin
            step();
            check("dropped_write_no_valid", resp_valid, 0);
        end
        txn(1'b0, 32'h0000_0020, 32'h0, 0, 1'b0);
        txn(1'b0, 32'h0000_003F, 32'h0, 0, 1'b0);
        // Earlier aliasing write is gone after reset.
        txn(1'b0, 32'h0000_0005, 32'h0, 1, 1'b0);

        // Randomized traffic over a small window so reads often hit written words.
        for (int n = 0; n < 40; n++) begin
            wr = $urandom_range(0, 1);
            a  = {$urandom_range(0, 3) == 0 ? $urandom : 32'h0} & 32'hFFFF_FF00;
            a  = a | 32'($urandom_range(0, 15));
            txn(wr, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 1));
        end

        repeat (2) step();
        check("one_valid_per_request", valid_rises, accepted);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
